// File: rtl/hp_manager.sv
// Player hit-point manager: tracks HP, runs the post-hit invincibility window
// with frame-aligned icon blinking, and flags game over when HP reaches zero.
module hp_manager #(
   parameter int HP_MAX       = 5,
   parameter int INV_FRAMES   = 60,
   parameter int BLINK_FRAMES = 8
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic       frame_tick,
   input  logic       hit,
   input  logic       heal,
   output logic [2:0] HP_value,
   output logic       enable,
   output logic       gameover,
   output logic       hit_ack
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_ALIVE,
      S_INVINCIBLE,
      S_DEAD
   } state_e;

   localparam logic [2:0] HpMax       = 3'(HP_MAX);
   localparam logic [7:0] InvFrames   = 8'(INV_FRAMES);
   localparam logic [7:0] BlinkFrames = 8'(BLINK_FRAMES);

   state_e     state_q, state_d;
   logic [2:0] hp_q, hp_d;
   logic       en_q, en_d;
   logic       go_q, go_d;
   logic       ack_q, ack_d;
   logic [7:0] inv_q, inv_d;
   logic [7:0] blink_q, blink_d;

   always_comb begin
      // NOTE: every _d gets a default before any branch so no path can infer a latch.
      state_d = state_q;
      hp_d    = hp_q;
      en_d    = en_q;
      go_d    = go_q;
      ack_d   = 1'b0;
      inv_d   = inv_q;
      blink_d = blink_q;

      if (start) begin
         state_d = S_ALIVE;
         hp_d    = HpMax;
         en_d    = 1'b1;
         go_d    = 1'b0;
         inv_d   = '0;
         blink_d = '0;
      end else begin
         unique case (state_q)
            S_IDLE: ;
            S_ALIVE: begin
               if (hit) begin
                  ack_d = 1'b1;
                  if (hp_q <= 3'd1) begin
                     hp_d    = '0;
                     state_d = S_DEAD;
                     go_d    = 1'b1;
                     en_d    = 1'b1;
                  end else begin
                     hp_d    = hp_q - 3'd1;
                     state_d = S_INVINCIBLE;
                     inv_d   = InvFrames;
                     blink_d = '0;
                     en_d    = 1'b0;
                  end
               end else if (heal && hp_q < HpMax) begin
                  hp_d = hp_q + 3'd1;
               end
            end
            S_INVINCIBLE: begin
               if (heal && hp_q < HpMax) hp_d = hp_q + 3'd1;
               // The window only advances on frame boundaries, so blinking stays frame-aligned.
               if (frame_tick) begin
                  if (inv_q <= 8'd1) begin
                     inv_d   = '0;
                     blink_d = '0;
                     state_d = S_ALIVE;
                     en_d    = 1'b1;
                  end else begin
                     inv_d = inv_q - 8'd1;
                     if (blink_q + 8'd1 >= BlinkFrames) begin
                        blink_d = '0;
                        en_d    = ~en_q;
                     end else begin
                        blink_d = blink_q + 8'd1;
                     end
                  end
               end
            end
            S_DEAD: begin
               hp_d = '0;
               go_d = 1'b1;
            end
            default: state_d = S_IDLE;
         endcase
      end
   end

   // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         hp_q    <= '0;
         en_q    <= 1'b0;
         go_q    <= 1'b0;
         ack_q   <= 1'b0;
         inv_q   <= '0;
         blink_q <= '0;
      end else begin
         state_q <= state_d;
         hp_q    <= hp_d;
         en_q    <= en_d;
         go_q    <= go_d;
         ack_q   <= ack_d;
         inv_q   <= inv_d;
         blink_q <= blink_d;
      end
   end

   assign HP_value = hp_q;
   assign enable   = en_q;
   assign gameover = go_q;
   assign hit_ack  = ack_q;

endmodule
